// File: rtl/fxp_div_seq_pkg.sv
// Shared definitions for the sequential fixed-point divider.
//   - Default operand width and fractional-bit count (Q8.8 build).
//   - NW: width of the pre-shifted dividend, and so the number of restoring steps.
//   - Signed saturation limits for the default width.
//   - FSM state encoding.
package fxp_div_seq_pkg;

  localparam int CNN_XLEN      = 16;
  localparam int AUG_FCT_B_DEF = 8;
  localparam int NW            = CNN_XLEN + AUG_FCT_B_DEF;

  localparam logic signed [CNN_XLEN-1:0] FXP_MAX = {1'b0, {(CNN_XLEN-1){1'b1}}};
  localparam logic signed [CNN_XLEN-1:0] FXP_MIN = {1'b1, {(CNN_XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fxp_div_seq_if.sv
// Handshake bundle of the divider.
//   in_valid/in_ready  : operand handshake, A (dividend), B (divisor)
//   out_valid/out_ready: result handshake, OUT (quotient), div_by_zero, ovf
// master = producer/consumer side, slave = the divider.
interface fxp_div_seq_if
  import fxp_div_seq_pkg::*;
#(
  parameter int DATA_WID = CNN_XLEN
);
  logic                in_valid;
  logic                in_ready;
  logic [DATA_WID-1:0] A;
  logic [DATA_WID-1:0] B;
  logic                out_valid;
  logic                out_ready;
  logic [DATA_WID-1:0] OUT;
  logic                div_by_zero;
  logic                ovf;

  modport master (
    output in_valid, A, B, out_ready,
    input  in_ready, out_valid, OUT, div_by_zero, ovf
  );

  modport slave (
    input  in_valid, A, B, out_ready,
    output in_ready, out_valid, OUT, div_by_zero, ovf
  );
endinterface

// File: rtl/fxp_div_step.sv
// One combinational restoring-division step on unsigned magnitudes.
//   i_rem  : current partial remainder (always < divisor, so DATA_WID bits suffice)
//   i_bit  : next dividend bit shifted into the remainder
//   i_div  : divisor magnitude
//   o_rem  : next partial remainder
//   o_qbit : quotient bit produced by this step
module fxp_div_step #(
  parameter int DATA_WID = 16
) (
  input  logic [DATA_WID-1:0] i_rem,
  input  logic                i_bit,
  input  logic [DATA_WID-1:0] i_div,
  output logic [DATA_WID-1:0] o_rem,
  output logic                o_qbit
);

  logic [DATA_WID:0]   w_sh;
  logic [DATA_WID-1:0] w_diff;

  assign w_sh   = {i_rem, i_bit};
  assign o_qbit = (w_sh >= {1'b0, i_div});
  // When the trial subtract succeeds the true difference is below the
  // divisor, so the modulo-2^DATA_WID difference is exact.
  assign w_diff = w_sh[DATA_WID-1:0] - i_div;
  assign o_rem  = o_qbit ? w_diff : w_sh[DATA_WID-1:0];

endmodule

// File: rtl/fxp_div_seq.sv
// Sequential signed fixed-point divider: OUT = (A << AUG_FCT_B) / B, truncated
// toward zero, same Q format as the fixed-point multiplier. Radix-2 restoring
// division on magnitudes, one quotient bit per clock.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset (aborts any division in flight)
//   bus    : fxp_div_seq_if.slave (in_valid/in_ready/A/B, out_valid/out_ready/OUT/div_by_zero/ovf)
// Configuration macro FXP_DIV_SAT_EN:
//   defined   : overflow and divide-by-zero results saturate to MAX/MIN
//   undefined : OUT is the low DATA_WID bits of the quotient; divide-by-zero gives 0
module fxp_div_seq
  import fxp_div_seq_pkg::*;
#(
  parameter int DATA_WID  = CNN_XLEN,
  parameter int AUG_FCT_B = AUG_FCT_B_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  fxp_div_seq_if.slave bus
);

  localparam int W_NUM = DATA_WID + AUG_FCT_B;
  localparam int CW    = $clog2(W_NUM);

  localparam logic [W_NUM-1:0] MAG_MAX =
    {{(W_NUM-DATA_WID+1){1'b0}}, {(DATA_WID-1){1'b1}}};
  localparam logic [W_NUM-1:0] MAG_MIN = MAG_MAX + 1'b1;

  localparam logic [DATA_WID-1:0] SAT_MAX = {1'b0, {(DATA_WID-1){1'b1}}};
  localparam logic [DATA_WID-1:0] SAT_MIN = {1'b1, {(DATA_WID-1){1'b0}}};

  state_t              r_state;
  logic                r_in_ready;
  logic                r_out_valid;
  logic [DATA_WID-1:0] r_out;
  logic                r_dbz;
  logic                r_ovf;
  logic                r_sign;
  logic [DATA_WID-1:0] r_div;
  logic [DATA_WID-1:0] r_rem;
  logic [W_NUM-1:0]    r_quo;
  logic [CW-1:0]       r_cnt;

  logic signed [DATA_WID-1:0] w_a_s;
  logic signed [DATA_WID-1:0] w_b_s;
  logic [DATA_WID-1:0]        w_a_mag;
  logic [DATA_WID-1:0]        w_b_mag;
  logic                       w_sign_in;
  logic [DATA_WID-1:0]        w_rem_nxt;
  logic                       w_qbit;
  logic [W_NUM-1:0]           w_q_mag;
  logic                       w_ovf;
  logic [DATA_WID-1:0]        w_res;
  logic [DATA_WID-1:0]        w_dbz_res;

  function automatic logic is_ovf(input logic [W_NUM-1:0] mag, input logic neg);
    return neg ? (mag > MAG_MIN) : (mag > MAG_MAX);
  endfunction

  // Low DATA_WID bits of the signed quotient; negating the low bits alone is
  // exact modulo 2^DATA_WID.
  function automatic logic [DATA_WID-1:0] wrap_res(input logic [DATA_WID-1:0] mag_lo,
                                                   input logic neg);
    return neg ? (~mag_lo + 1'b1) : mag_lo;
  endfunction

`ifdef FXP_DIV_SAT_EN
  function automatic logic [DATA_WID-1:0] sat_val(input logic neg);
    return neg ? SAT_MIN : SAT_MAX;
  endfunction
`endif

  assign w_a_s     = bus.A;
  assign w_b_s     = bus.B;
  // Unsigned magnitudes: the most negative value maps to 2^(DATA_WID-1).
  assign w_a_mag   = w_a_s[DATA_WID-1] ? -w_a_s : w_a_s;
  assign w_b_mag   = w_b_s[DATA_WID-1] ? -w_b_s : w_b_s;
  assign w_sign_in = w_a_s[DATA_WID-1] ^ w_b_s[DATA_WID-1];

  // r_quo starts as the shifted dividend; its MSB feeds the remainder each
  // step while quotient bits enter at the LSB.
  fxp_div_step #(.DATA_WID(DATA_WID)) u_step (
    .i_rem  (r_rem),
    .i_bit  (r_quo[W_NUM-1]),
    .i_div  (r_div),
    .o_rem  (w_rem_nxt),
    .o_qbit (w_qbit)
  );

  assign w_q_mag = {r_quo[W_NUM-2:0], w_qbit};
  assign w_ovf   = is_ovf(w_q_mag, r_sign);

`ifdef FXP_DIV_SAT_EN
  assign w_res     = w_ovf ? sat_val(r_sign) : wrap_res(w_q_mag[DATA_WID-1:0], r_sign);
  // With B == 0 the sign is just the sign of A.
  assign w_dbz_res = sat_val(w_sign_in);
`else
  assign w_res     = wrap_res(w_q_mag[DATA_WID-1:0], r_sign);
  assign w_dbz_res = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out       <= '0;
      r_dbz       <= 1'b0;
      r_ovf       <= 1'b0;
      r_sign      <= 1'b0;
      r_div       <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_cnt       <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.in_valid && r_in_ready) begin
            r_sign     <= w_sign_in;
            r_div      <= w_b_mag;
            r_rem      <= '0;
            r_quo      <= W_NUM'(w_a_mag) << AUG_FCT_B;
            r_cnt      <= CW'(W_NUM - 1);
            r_in_ready <= 1'b0;
            r_ovf      <= 1'b0;
            if (w_b_mag == '0) begin
              r_state     <= S_DONE;
              r_out_valid <= 1'b1;
              r_dbz       <= 1'b1;
              r_out       <= w_dbz_res;
            end else begin
              r_state <= S_BUSY;
              r_dbz   <= 1'b0;
            end
          end
        end

        S_BUSY: begin
          r_rem <= w_rem_nxt;
          r_quo <= w_q_mag;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == '0) begin
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
            r_ovf       <= w_ovf;
            r_out       <= w_res;
          end
        end

        S_DONE: begin
          if (bus.out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end

        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready    = r_in_ready;
  assign bus.out_valid   = r_out_valid;
  assign bus.OUT         = r_out;
  assign bus.div_by_zero = r_dbz;
  assign bus.ovf         = r_ovf;

endmodule

// File: tb/tb_fxp_div_seq.sv
// Directed + random bench for fxp_div_seq in the Q8.8 build (DATA_WID=16,
// AUG_FCT_B=8). Expected results are queued when operands are driven and
// popped when the divider presents a result. Honours FXP_DIV_SAT_EN.
module tb_fxp_div_seq;

  localparam int W = 16;
  localparam int F = 8;

  typedef struct packed {
    logic [W-1:0] out;
    logic         dbz;
    logic         ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fxp_div_seq_if #(.DATA_WID(W)) bus ();

  fxp_div_seq #(.DATA_WID(W), .AUG_FCT_B(F)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      $error("check %s", tag);
    end
  endtask

  // Reference: integer division truncates toward zero.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t   e;
    longint na, nb, q;
    na    = $signed(a);
    nb    = $signed(b);
    e.dbz = (b == '0);
    e.ovf = 1'b0;
    if (b == '0) begin
`ifdef FXP_DIV_SAT_EN
      e.out = (na < 0) ? 16'h8000 : 16'h7FFF;
`else
      e.out = 16'h0000;
`endif
    end else begin
      q     = (na * 256) / nb;
      e.ovf = (q > 32767) || (q < -32768);
      e.out = q[W-1:0];
`ifdef FXP_DIV_SAT_EN
      if (e.ovf) e.out = (q < 0) ? 16'h8000 : 16'h7FFF;
`endif
    end
    return e;
  endfunction

  // Drive one operation, measure accept-to-out_valid latency, check the
  // result; with hold=1 keep out_ready low for 10 cycles while poking in_valid.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input exp_t e, input int exp_lat, input bit hold);
    int           lat;
    exp_t         want;
    logic [W-1:0] held;
    @(negedge clk);
    chk({tag, "_in_ready"}, bus.in_ready, 1);
    bus.out_ready = !hold;
    bus.in_valid  = 1'b1;
    bus.A         = a;
    bus.B         = b;
    sb.push_back(e);
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      if (lat == 0) begin
        bus.in_valid = 1'b0;
        bus.A        = 16'($urandom);
        bus.B        = 16'($urandom);
      end
      lat++;
    end while (!bus.out_valid && lat < 100);
    chk({tag, "_latency"}, lat, exp_lat);
    want = sb.pop_front();
    chk({tag, "_out"}, bus.OUT, want.out);
    chk({tag, "_dbz"}, bus.div_by_zero, want.dbz);
    chk({tag, "_ovf"}, bus.ovf, want.ovf);
    if (hold) begin
      held = bus.OUT;
      for (int i = 0; i < 10; i++) begin
        bus.in_valid = 1'b1;
        bus.A        = 16'h0100;
        bus.B        = 16'h0000;
        @(negedge clk);
        chk({tag, "_hold_valid"}, bus.out_valid, 1);
        chk({tag, "_hold_out"}, bus.OUT, held);
        chk({tag, "_hold_flags"}, {bus.div_by_zero, bus.ovf}, {want.dbz, want.ovf});
        chk({tag, "_hold_in_ready"}, bus.in_ready, 0);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
    end
    @(negedge clk);
    chk({tag, "_consumed"}, bus.out_valid, 0);
    chk({tag, "_ready_again"}, bus.in_ready, 1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, bus.in_ready, 1);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_out"}, bus.OUT, 0);
    chk({tag, "_dbz"}, bus.div_by_zero, 0);
    chk({tag, "_ovf"}, bus.ovf, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t         e;
    logic [W-1:0] ra, rb;
    int           vld_seen;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.A         = '0;
    bus.B         = '0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;

    // 1.5 / 0.5 = 3.0
    e = '{out: 16'h0300, dbz: 1'b0, ovf: 1'b0};
    run_op("pos", 16'h0180, 16'h0080, e, 25, 1'b0);
    // -1.5 / 0.5 = -3.0
    e = '{out: 16'hFD00, dbz: 1'b0, ovf: 1'b0};
    run_op("neg", 16'hFE80, 16'h0080, e, 25, 1'b0);
    // tiny positive / 3.0 truncates to 0
    e = '{out: 16'h0000, dbz: 1'b0, ovf: 1'b0};
    run_op("trunc_pos", 16'h0001, 16'h0300, e, 25, 1'b0);
    // tiny negative / 3.0 truncates toward zero
    e = '{out: 16'h0000, dbz: 1'b0, ovf: 1'b0};
    run_op("trunc_neg", 16'hFFFF, 16'h0300, e, 25, 1'b0);
    // overflow
`ifdef FXP_DIV_SAT_EN
    e = '{out: 16'h7FFF, dbz: 1'b0, ovf: 1'b1};
`else
    e = '{out: 16'hFC00, dbz: 1'b0, ovf: 1'b1};
`endif
    run_op("ovf", 16'h7F00, 16'h0040, e, 25, 1'b0);
    // divide by zero
`ifdef FXP_DIV_SAT_EN
    e = '{out: 16'h7FFF, dbz: 1'b1, ovf: 1'b0};
`else
    e = '{out: 16'h0000, dbz: 1'b1, ovf: 1'b0};
`endif
    run_op("dbz", 16'h0100, 16'h0000, e, 1, 1'b0);
    // negative dividend over zero
`ifdef FXP_DIV_SAT_EN
    e = '{out: 16'h8000, dbz: 1'b1, ovf: 1'b0};
`else
    e = '{out: 16'h0000, dbz: 1'b1, ovf: 1'b0};
`endif
    run_op("dbz_neg", 16'hFF00, 16'h0000, e, 1, 1'b0);
    // -128.0 / -128.0 = 1.0 (most negative magnitudes)
    e = '{out: 16'h0100, dbz: 1'b0, ovf: 1'b0};
    run_op("minmin", 16'h8000, 16'h8000, e, 25, 1'b0);
    // -0.5 / 0.00390625 = -128.0 exactly: boundary, no overflow
    e = '{out: 16'h8000, dbz: 1'b0, ovf: 1'b0};
    run_op("neg_edge", 16'hFF80, 16'h0001, e, 25, 1'b0);
    // +0.5 / 0.00390625 = +128.0: just over the positive limit
`ifdef FXP_DIV_SAT_EN
    e = '{out: 16'h7FFF, dbz: 1'b0, ovf: 1'b1};
`else
    e = '{out: 16'h8000, dbz: 1'b0, ovf: 1'b1};
`endif
    run_op("pos_edge", 16'h0080, 16'h0001, e, 25, 1'b0);

    // Backpressure: result held for 10 cycles, new requests ignored.
    e = '{out: 16'hFA00, dbz: 1'b0, ovf: 1'b0};
    run_op("hold", 16'h0300, 16'hFF80, e, 25, 1'b1);
    e = '{out: 16'h0200, dbz: 1'b0, ovf: 1'b0};
    run_op("after_hold", 16'h0100, 16'h0080, e, 25, 1'b0);

    // Reset in the middle of a division.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.A        = 16'h0180;
    bus.B        = 16'h0080;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("mid_reset");
    vld_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.out_valid) vld_seen++;
    end
    chk("mid_reset_no_valid", vld_seen, 0);
    rst_n = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (bus.out_valid) vld_seen++;
    end
    chk("post_reset_no_valid", vld_seen, 0);
    e = '{out: 16'h0300, dbz: 1'b0, ovf: 1'b0};
    run_op("post_reset", 16'h0180, 16'h0080, e, 25, 1'b0);

    // Random operands against the reference model.
    for (int i = 0; i < 10; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (i == 3) rb = 16'h8000;
      if (i == 6) rb = 16'h0000;
      if (i == 8) ra = 16'h8000;
      run_op("rand", ra, rb, model(ra, rb), (rb == '0) ? 1 : 25, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
